// File: rtl/anti_spoof_top.sv
// Anti-impersonation alarm: zone latching, debounced keypad code entry, spoof
// detection, buzzer, 7-segment status digit and HD44780 message writer.
module anti_spoof_top #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned E_PULSE         = 50,
  parameter int unsigned CMD_WAIT        = 5000,
  parameter int unsigned CLEAR_WAIT      = 200000,
  parameter int unsigned POWERUP_WAIT    = 2000000,
  parameter int unsigned BUZZ_DIV        = 50000,
  parameter logic [7:0]  PASSCODE        = 8'h19,
  parameter int unsigned MAX_FAIL        = 3
) (
  input  logic       clk,
  input  logic       rst2,
  input  logic [1:0] etapa,
  input  logic [2:0] sensor,
  input  logic       enter,
  input  logic [3:0] fila,
  input  logic [2:0] Columna,
  output logic       rw,
  output logic       rs,
  output logic       e,
  output logic [6:0] disp,
  output logic [7:0] lcd_db,
  output logic       buzzer_out,
  output logic       alarm_out1,
  output logic       alarm_out2
);

  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [2:0] {
    LCD_POWERUP,
    LCD_INIT_PULSE,
    LCD_INIT_WAIT,
    LCD_IDLE,
    LCD_WR_PULSE,
    LCD_WR_WAIT
  } lcdState_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] initByte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h06;
      default: b = 8'h01;
    endcase
    return b;
  endfunction

  // Message ids: 0 disarmed, 1 watching, 2 alarm, 3 new code, 4 enter code.
  function automatic logic [7:0] msgChar(input logic [2:0] msg, input logic [3:0] idx);
    logic [127:0] s;
    case (msg)
      3'd1:    s = "VIGILANDO       ";
      3'd2:    s = "ALARMA ACTIVA   ";
      3'd3:    s = "NUEVA CLAVE     ";
      3'd4:    s = "INGRESE CLAVE   ";
      default: s = "DESARMADO       ";
    endcase
    s = s << {idx, 3'b000};
    return s[127:120];
  endfunction

  // Keypad debounce: a code must hold for DEBOUNCE_CYCLES; after a key the
  // lock releases only once all lines have been idle for the same time.
  logic [6:0]  r_keyRaw;
  logic [31:0] r_keyCnt;
  logic        r_keyLocked;
  logic [6:0]  w_keyNow;
  logic        w_keyStable;
  logic        w_keyValid;
  logic        w_keyIsDigit;
  logic [3:0]  w_keyDigit;
  logic        w_digitPulse;

  assign w_keyNow     = {fila, Columna};
  assign w_keyStable  = (w_keyNow == r_keyRaw) && (r_keyCnt == DEBOUNCE_CYCLES - 1);
  assign w_digitPulse = w_keyStable && !r_keyLocked && w_keyValid && w_keyIsDigit;

  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_keyRaw    <= '0;
      r_keyCnt    <= '0;
      r_keyLocked <= 1'b0;
    end else begin
      r_keyRaw <= w_keyNow;
      if (w_keyNow != r_keyRaw)
        r_keyCnt <= '0;
      else if (r_keyCnt < DEBOUNCE_CYCLES)
        r_keyCnt <= r_keyCnt + 32'd1;
      if (w_keyStable) begin
        if (!r_keyLocked && w_keyValid)
          r_keyLocked <= 1'b1;
        else if (r_keyLocked && (r_keyRaw == 7'd0))
          r_keyLocked <= 1'b0;
      end
    end
  end

  always_comb begin
    logic [3:0] colIdx;
    colIdx       = 4'd0;
    w_keyDigit   = 4'd0;
    w_keyIsDigit = 1'b0;
    w_keyValid   = $onehot(r_keyRaw[6:3]) && $onehot(r_keyRaw[2:0]);
    case (r_keyRaw[2:0])
      3'b010:  colIdx = 4'd1;
      3'b100:  colIdx = 4'd2;
      default: colIdx = 4'd0;
    endcase
    case (r_keyRaw[6:3])
      4'b0001: begin w_keyDigit = 4'd1 + colIdx; w_keyIsDigit = 1'b1; end
      4'b0010: begin w_keyDigit = 4'd4 + colIdx; w_keyIsDigit = 1'b1; end
      4'b0100: begin w_keyDigit = 4'd7 + colIdx; w_keyIsDigit = 1'b1; end
      4'b1000: begin w_keyDigit = 4'd0; w_keyIsDigit = (colIdx == 4'd1); end
      default: begin w_keyDigit = 4'd0; w_keyIsDigit = 1'b0; end
    endcase
  end

  logic        r_entRaw;
  logic        r_entLevel;
  logic [31:0] r_entCnt;
  logic        w_entStable;
  logic        w_enterPulse;

  assign w_entStable  = (enter == r_entRaw) && (r_entCnt == DEBOUNCE_CYCLES - 1);
  assign w_enterPulse = w_entStable && r_entRaw && !r_entLevel;

  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_entRaw   <= 1'b0;
      r_entLevel <= 1'b0;
      r_entCnt   <= '0;
    end else begin
      r_entRaw <= enter;
      if (enter != r_entRaw)
        r_entCnt <= '0;
      else if (r_entCnt < DEBOUNCE_CYCLES)
        r_entCnt <= r_entCnt + 32'd1;
      if (w_entStable)
        r_entLevel <= r_entRaw;
    end
  end

  logic [7:0] r_buf;
  logic [1:0] r_count;
  logic [1:0] r_etapaPrev;
  logic       w_etapaChg;

  assign w_etapaChg = (etapa != r_etapaPrev);

  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_buf       <= '0;
      r_count     <= '0;
      r_etapaPrev <= '0;
    end else begin
      r_etapaPrev <= etapa;
      if (w_enterPulse || w_etapaChg) begin
        r_buf   <= '0;
        r_count <= '0;
      end else if (w_digitPulse) begin
        r_buf   <= {r_buf[3:0], w_keyDigit};
        r_count <= (r_count == 2'd2) ? 2'd2 : r_count + 2'd1;
      end
    end
  end

  logic [2:0] r_zone;
  logic       r_alarm1;
  logic       r_alarm2;
  logic [3:0] r_fail;
  logic [7:0] r_code;
  logic       w_codeMatch;

  assign w_codeMatch = (r_count == 2'd2) && (r_buf == r_code);

  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_zone   <= '0;
      r_alarm1 <= 1'b0;
      r_alarm2 <= 1'b0;
      r_fail   <= '0;
      r_code   <= PASSCODE;
    end else begin
      case (etapa)
        2'b01: begin
          r_zone <= r_zone | sensor;
          if (|sensor)
            r_alarm1 <= 1'b1;
        end
        2'b10: begin
          if (w_enterPulse && (r_count == 2'd2) && !r_alarm1 && !r_alarm2)
            r_code <= r_buf;
        end
        2'b11: begin
          if (w_enterPulse) begin
            if (w_codeMatch) begin
              r_zone   <= '0;
              r_alarm1 <= 1'b0;
              r_alarm2 <= 1'b0;
              r_fail   <= '0;
            end else begin
              if (r_fail < 4'(MAX_FAIL))
                r_fail <= r_fail + 4'd1;
              if (r_fail + 4'd1 >= 4'(MAX_FAIL))
                r_alarm2 <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [31:0] r_buzzCnt;
  logic        r_buzz;

  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_buzzCnt <= '0;
      r_buzz    <= 1'b0;
    end else if (r_alarm1 || r_alarm2) begin
      if (r_buzzCnt == BUZZ_DIV - 1) begin
        r_buzzCnt <= '0;
        r_buzz    <= ~r_buzz;
      end else begin
        r_buzzCnt <= r_buzzCnt + 32'd1;
      end
    end else begin
      r_buzzCnt <= '0;
      r_buzz    <= 1'b0;
    end
  end

  logic [6:0] r_disp;
  logic [1:0] w_zoneCount;

  assign w_zoneCount = 2'(r_zone[0]) + 2'(r_zone[1]) + 2'(r_zone[2]);

  always_ff @(posedge clk) begin
    if (!rst2)
      r_disp <= 7'b1000000;
    else if (etapa[1])
      r_disp <= (r_count == 2'd0) ? SEG_DASH : seg7(r_buf[3:0]);
    else
      r_disp <= seg7({2'b00, w_zoneCount});
  end

  lcdState_t   r_lcdState;
  lcdState_t   w_lcdNext;
  logic [31:0] r_lcdCnt;
  logic [4:0]  r_lcdIdx;
  logic [2:0]  r_shownMsg;
  logic [2:0]  w_msgSel;
  logic        r_rs;
  logic        r_e;
  logic [7:0]  r_db;
  logic [31:0] w_waitLimit;
  logic        w_cntClr;
  logic        w_load;
  logic        w_loadRs;
  logic [7:0]  w_loadByte;
  logic        w_idxClr;
  logic        w_idxInc;
  logic        w_latchMsg;
  logic        w_eDrop;

  always_comb begin
    if (etapa == 2'b11)              w_msgSel = 3'd4;
    else if (etapa == 2'b10)         w_msgSel = 3'd3;
    else if (r_alarm1 || r_alarm2)   w_msgSel = 3'd2;
    else if (etapa == 2'b01)         w_msgSel = 3'd1;
    else                             w_msgSel = 3'd0;
  end

  // The clear command needs the long settle time; r_db still holds it.
  assign w_waitLimit = (r_db == 8'h01) ? CLEAR_WAIT : CMD_WAIT;

  always_ff @(posedge clk) begin
    if (!rst2)
      r_lcdState <= LCD_POWERUP;
    else
      r_lcdState <= w_lcdNext;
  end

  always_comb begin
    w_lcdNext  = r_lcdState;
    w_cntClr   = 1'b0;
    w_load     = 1'b0;
    w_loadRs   = 1'b0;
    w_loadByte = 8'h00;
    w_idxClr   = 1'b0;
    w_idxInc   = 1'b0;
    w_latchMsg = 1'b0;
    w_eDrop    = 1'b0;
    case (r_lcdState)
      LCD_POWERUP: begin
        if (r_lcdCnt == POWERUP_WAIT - 1) begin
          w_lcdNext  = LCD_INIT_PULSE;
          w_cntClr   = 1'b1;
          w_load     = 1'b1;
          w_loadByte = initByte(2'd0);
          w_idxClr   = 1'b1;
        end
      end
      LCD_INIT_PULSE: begin
        if (r_lcdCnt == E_PULSE - 1) begin
          w_lcdNext = LCD_INIT_WAIT;
          w_cntClr  = 1'b1;
          w_eDrop   = 1'b1;
        end
      end
      LCD_INIT_WAIT: begin
        if (r_lcdCnt == w_waitLimit - 32'd1) begin
          w_cntClr = 1'b1;
          if (r_lcdIdx == 5'd3) begin
            w_lcdNext = LCD_IDLE;
          end else begin
            w_lcdNext  = LCD_INIT_PULSE;
            w_load     = 1'b1;
            w_loadByte = initByte(r_lcdIdx[1:0] + 2'd1);
            w_idxInc   = 1'b1;
          end
        end
      end
      LCD_IDLE: begin
        if (w_msgSel != r_shownMsg) begin
          w_lcdNext  = LCD_WR_PULSE;
          w_cntClr   = 1'b1;
          w_load     = 1'b1;
          w_loadByte = 8'h80;
          w_idxClr   = 1'b1;
          w_latchMsg = 1'b1;
        end
      end
      LCD_WR_PULSE: begin
        if (r_lcdCnt == E_PULSE - 1) begin
          w_lcdNext = LCD_WR_WAIT;
          w_cntClr  = 1'b1;
          w_eDrop   = 1'b1;
        end
      end
      LCD_WR_WAIT: begin
        if (r_lcdCnt == CMD_WAIT - 1) begin
          w_cntClr = 1'b1;
          if (r_lcdIdx == 5'd16) begin
            w_lcdNext = LCD_IDLE;
          end else begin
            w_lcdNext  = LCD_WR_PULSE;
            w_load     = 1'b1;
            w_loadRs   = 1'b1;
            w_loadByte = msgChar(r_shownMsg, r_lcdIdx[3:0]);
            w_idxInc   = 1'b1;
          end
        end
      end
      default: w_lcdNext = LCD_POWERUP;
    endcase
  end

  // Id 7 never matches a real message, so the first pass through IDLE writes.
  always_ff @(posedge clk) begin
    if (!rst2) begin
      r_lcdCnt   <= '0;
      r_lcdIdx   <= '0;
      r_shownMsg <= 3'd7;
      r_rs       <= 1'b0;
      r_e        <= 1'b0;
      r_db       <= '0;
    end else begin
      if (w_cntClr)
        r_lcdCnt <= '0;
      else if (r_lcdState != LCD_IDLE)
        r_lcdCnt <= r_lcdCnt + 32'd1;
      if (w_idxClr)
        r_lcdIdx <= '0;
      else if (w_idxInc)
        r_lcdIdx <= r_lcdIdx + 5'd1;
      if (w_latchMsg)
        r_shownMsg <= w_msgSel;
      if (w_load) begin
        r_rs <= w_loadRs;
        r_db <= w_loadByte;
        r_e  <= 1'b1;
      end else if (w_eDrop) begin
        r_e <= 1'b0;
      end
    end
  end

  assign rw         = 1'b0;
  assign rs         = r_rs;
  assign e          = r_e;
  assign lcd_db     = r_db;
  assign disp       = r_disp;
  assign buzzer_out = r_buzz;
  assign alarm_out1 = r_alarm1;
  assign alarm_out2 = r_alarm2;

endmodule

// File: tb/tb_anti_spoof_top.sv
// Directed bench for anti_spoof_top with shortened timing parameters so the
// LCD init, debounce and buzzer behaviour fit in a few thousand cycles.
module tb_anti_spoof_top;

  localparam int DEB = 4;
  localparam int BUZZ = 8;

  logic       clk;
  logic       rst2;
  logic [1:0] etapa;
  logic [2:0] sensor;
  logic       enter;
  logic [3:0] fila;
  logic [2:0] Columna;
  logic       rw;
  logic       rs;
  logic       e;
  logic [6:0] disp;
  logic [7:0] lcd_db;
  logic       buzzer_out;
  logic       alarm_out1;
  logic       alarm_out2;

  int errors = 0;
  int checks = 0;
  int period;
  int mark;

  logic [8:0] lcdQ[$];
  logic [8:0] heldByte = 9'h000;
  logic       ePrev = 1'b0;
  logic       lcdUnstable = 1'b0;

  anti_spoof_top #(
    .DEBOUNCE_CYCLES(DEB),
    .E_PULSE(2),
    .CMD_WAIT(5),
    .CLEAR_WAIT(10),
    .POWERUP_WAIT(20),
    .BUZZ_DIV(BUZZ),
    .PASSCODE(8'h19),
    .MAX_FAIL(3)
  ) dut (
    .clk(clk),
    .rst2(rst2),
    .etapa(etapa),
    .sensor(sensor),
    .enter(enter),
    .fila(fila),
    .Columna(Columna),
    .rw(rw),
    .rs(rs),
    .e(e),
    .disp(disp),
    .lcd_db(lcd_db),
    .buzzer_out(buzzer_out),
    .alarm_out1(alarm_out1),
    .alarm_out2(alarm_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every LCD strobe as {rs, data} and flag bus changes while e is high.
  always @(negedge clk) begin
    if (e && ePrev && ({rs, lcd_db} != heldByte))
      lcdUnstable = 1'b1;
    if (e && !ePrev) begin
      lcdQ.push_back({rs, lcd_db});
      heldByte = {rs, lcd_db};
    end
    ePrev = e;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold a keypad/enter pattern long enough to be accepted, then release it.
  task automatic applyStimulus(input logic [3:0] f, input logic [2:0] c, input logic en);
    @(negedge clk);
    fila = f;
    Columna = c;
    enter = en;
    tick(DEB + 4);
    fila = 4'b0000;
    Columna = 3'b000;
    enter = 1'b0;
    tick(DEB + 4);
  endtask

  task automatic waitLcd(input int minBytes, input string tag);
    int quiet;
    bit done;
    quiet = 0;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      quiet = e ? 0 : quiet + 1;
      if (lcdQ.size() >= minBytes && quiet >= 30)
        done = 1'b1;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic checkLcdMsg(input string tag, input string msg);
    int n;
    n = lcdQ.size();
    checkOutput({tag, "_len"}, 32'(n >= 17), 32'd1);
    if (n >= 17) begin
      checkOutput({tag, "_addr"}, 32'(lcdQ[n-17]), 32'h080);
      for (int i = 0; i < 16; i++)
        checkOutput(tag, 32'(lcdQ[n-16+i]), 32'({1'b1, msg[i]}));
    end
  endtask

  task automatic measureBuzz(output int p);
    logic prev;
    prev = buzzer_out;
    for (int i = 0; i < 100 && buzzer_out === prev; i++)
      @(negedge clk);
    prev = buzzer_out;
    p = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      p++;
      if (buzzer_out !== prev)
        break;
    end
  endtask

  initial begin
    rst2 = 1'b0;
    etapa = 2'b00;
    sensor = 3'b000;
    enter = 1'b0;
    fila = 4'b0000;
    Columna = 3'b000;
    tick(5);
    rst2 = 1'b1;
    tick(2);
    checkOutput("rst_alarm1", 32'(alarm_out1), 32'd0);
    checkOutput("rst_alarm2", 32'(alarm_out2), 32'd0);
    checkOutput("rst_buzzer", 32'(buzzer_out), 32'd0);
    checkOutput("rst_e", 32'(e), 32'd0);
    checkOutput("rst_rw", 32'(rw), 32'd0);
    checkOutput("rst_disp", 32'(disp), 32'h40);

    waitLcd(21, "lcd_boot");
    checkOutput("lcd_boot_count", 32'(lcdQ.size()), 32'd21);
    checkOutput("lcd_init0", 32'(lcdQ[0]), 32'h038);
    checkOutput("lcd_init1", 32'(lcdQ[1]), 32'h00C);
    checkOutput("lcd_init2", 32'(lcdQ[2]), 32'h006);
    checkOutput("lcd_init3", 32'(lcdQ[3]), 32'h001);
    checkLcdMsg("lcd_desarmado", "DESARMADO       ");

    $display("[TB] arming, zone 0 then zones 0 and 2");
    mark = lcdQ.size();
    etapa = 2'b01;
    sensor = 3'b001;
    tick(4);
    checkOutput("arm_alarm1", 32'(alarm_out1), 32'd1);
    checkOutput("arm_disp1", 32'(disp), 32'h79);
    sensor = 3'b101;
    tick(4);
    checkOutput("arm_disp2", 32'(disp), 32'h24);
    measureBuzz(period);
    checkOutput("buzz_period_a1", 32'(period), 32'(BUZZ));
    waitLcd(mark + 17, "lcd_alarm");
    checkLcdMsg("lcd_alarma", "ALARMA ACTIVA   ");
    sensor = 3'b000;
    tick(5);
    checkOutput("hold_alarm1", 32'(alarm_out1), 32'd1);
    checkOutput("hold_disp2", 32'(disp), 32'h24);

    $display("[TB] correct code 19 disarms");
    mark = lcdQ.size();
    etapa = 2'b11;
    tick(3);
    checkOutput("entry_empty_disp", 32'(disp), 32'h3F);
    waitLcd(mark + 17, "lcd_entry");
    checkLcdMsg("lcd_ingrese", "INGRESE CLAVE   ");
    applyStimulus(4'b0001, 3'b001, 1'b0);
    checkOutput("key1_disp", 32'(disp), 32'h79);
    applyStimulus(4'b0100, 3'b100, 1'b0);
    checkOutput("key9_disp", 32'(disp), 32'h10);
    applyStimulus(4'b0000, 3'b000, 1'b1);
    checkOutput("ok_alarm1", 32'(alarm_out1), 32'd0);
    checkOutput("ok_alarm2", 32'(alarm_out2), 32'd0);
    checkOutput("ok_buzzer", 32'(buzzer_out), 32'd0);
    checkOutput("ok_buf_clear", 32'(disp), 32'h3F);
    etapa = 2'b00;
    tick(3);
    checkOutput("ok_zones_clear", 32'(disp), 32'h40);

    $display("[TB] three wrong codes raise spoof alarm");
    etapa = 2'b11;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0001, 3'b010, 1'b0);
      applyStimulus(4'b0001, 3'b100, 1'b0);
      if (k == 1)
        checkOutput("key23_disp", 32'(disp), 32'h30);
      applyStimulus(4'b0000, 3'b000, 1'b1);
      checkOutput($sformatf("wrong%0d_alarm2", k + 1), 32'(alarm_out2), (k == 2) ? 32'd1 : 32'd0);
    end
    measureBuzz(period);
    checkOutput("buzz_period_a2", 32'(period), 32'(BUZZ));
    applyStimulus(4'b0001, 3'b001, 1'b0);
    applyStimulus(4'b0100, 3'b100, 1'b0);
    applyStimulus(4'b0000, 3'b000, 1'b1);
    checkOutput("spoof_clear_alarm2", 32'(alarm_out2), 32'd0);
    checkOutput("spoof_clear_buzzer", 32'(buzzer_out), 32'd0);

    $display("[TB] change code to 47");
    etapa = 2'b10;
    tick(3);
    applyStimulus(4'b0010, 3'b001, 1'b0);
    checkOutput("key4_disp", 32'(disp), 32'h19);
    applyStimulus(4'b0100, 3'b001, 1'b0);
    checkOutput("key7_disp", 32'(disp), 32'h78);
    applyStimulus(4'b0000, 3'b000, 1'b1);
    checkOutput("chg_buf_clear", 32'(disp), 32'h3F);

    etapa = 2'b01;
    sensor = 3'b010;
    tick(3);
    sensor = 3'b000;
    tick(2);
    checkOutput("rearm_alarm1", 32'(alarm_out1), 32'd1);
    checkOutput("rearm_disp", 32'(disp), 32'h79);

    etapa = 2'b11;
    tick(3);
    applyStimulus(4'b0011, 3'b001, 1'b0);
    checkOutput("twokey_disp", 32'(disp), 32'h3F);
    applyStimulus(4'b0001, 3'b001, 1'b0);
    applyStimulus(4'b0100, 3'b100, 1'b0);
    applyStimulus(4'b0000, 3'b000, 1'b1);
    checkOutput("old_code_alarm1", 32'(alarm_out1), 32'd1);
    checkOutput("old_code_alarm2", 32'(alarm_out2), 32'd0);
    applyStimulus(4'b0010, 3'b001, 1'b0);
    applyStimulus(4'b0100, 3'b001, 1'b0);
    applyStimulus(4'b0000, 3'b000, 1'b1);
    checkOutput("new_code_alarm1", 32'(alarm_out1), 32'd0);

    checkOutput("lcd_bus_stable", 32'(lcdUnstable), 32'd0);
    checkOutput("lcd_rw_const", 32'(rw), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anti_spoof_top.md
Name: anti_spoof_top

Overview:
Top level of the anti-impersonation alarm. Monitors 3 sensor zones, accepts a 2-digit access code from a directly wired 4x3 keypad (row/column lines, no scanning), and drives intrusion and spoof alarms, a buzzer, a 7-segment digit and an HD44780-style 8-bit LCD. Operating stage is selected externally by `etapa`.

Parameters:
DEBOUNCE_CYCLES, 500000, stable cycles needed to accept a key or enter press (5 ms at 100 MHz).
E_PULSE, 50, LCD enable high time in cycles.
CMD_WAIT, 5000, wait after each LCD command or character.
CLEAR_WAIT, 200000, wait after LCD clear (0x01).
POWERUP_WAIT, 2000000, wait after reset before the LCD init sequence.
BUZZ_DIV, 50000, buzzer half-period in cycles.
PASSCODE, 8'h19, reset value of the stored code (two BCD digits, first digit in [7:4]).
MAX_FAIL, 3, consecutive wrong codes that trigger the spoof alarm.

Ports:
clk  in  1  system clock, 100 MHz; all logic on its rising edge.
rst2  in  1  synchronous, active-low reset.
etapa  in  2  stage: 00 idle, 01 armed, 10 code change, 11 code entry.
sensor  in  3  zone sensors, active high.
enter  in  1  confirm button, active high.
fila  in  4  keypad row lines, one-hot.
Columna  in  3  keypad column lines, one-hot.
rw  out  1  LCD R/W; constant 0 (write only).
rs  out  1  LCD register select: 0 command, 1 data.
e  out  1  LCD enable strobe.
disp  out  7  7-segment digit {g,f,e,d,c,b,a}, active-low.
lcd_db  out  8  LCD data bus.
buzzer_out  out  1  buzzer square wave.
alarm_out1  out  1  intrusion alarm.
alarm_out2  out  1  spoof alarm (repeated wrong code).

Behaviour:
- Reset (rst2=0 at a clk edge): zone latches, alarms, buzzer, rw, rs, e and lcd_db go to 0. Digit buffer is emptied. Fail counter goes to 0. Stored code loads PASSCODE. disp shows "0" (7'b1000000). LCD FSM returns to POWERUP.
- Keypad decode: a key is valid only when exactly one `fila` bit and exactly one `Columna` bit are set.
  - Layout by row: row0 = 1 2 3; row1 = 4 5 6; row2 = 7 8 9; row3 = * 0 #. Columna[0] is the left column.
  - A key is accepted once, after DEBOUNCE_CYCLES of a stable valid code.
  - The next key is accepted only after all lines have been 0 for DEBOUNCE_CYCLES.
  - * and # are ignored.
- enter: debounced the same way; it acts once per press, on the accepted rising level.
- Digit buffer: 2-digit shift register with a count of 0..2. A new digit shifts in from the right; a 3rd digit discards the oldest. The buffer clears on every enter and on any etapa change.
- Stage 00, idle: sensors are ignored. Latches and alarms hold their state.
- Stage 01, armed: each cycle, zone_latch |= sensor.
  - alarm_out1 = OR of zone_latch; it stays high until a correct code is entered.
- Stage 10, code change:
  - enter with count=2 and both alarms low: stored code <= buffer.
  - Otherwise enter is ignored.
- Stage 11, code entry, on enter:
  - count=2 and buffer==stored code: clear zone_latch, alarm_out1, alarm_out2 and the fail counter.
  - Otherwise: fail counter +1, saturating. When it reaches MAX_FAIL, alarm_out2 is set.
- buzzer_out toggles every BUZZ_DIV cycles while alarm_out1|alarm_out2 is high, and is 0 otherwise.
- disp:
  - In stages 10 and 11: shows the last accepted digit, or "-" (7'b0111111) if the buffer is empty.
  - Otherwise: shows the number of set zone_latch bits (0..3).
- LCD FSM, sequence of states:
  - POWERUP (wait POWERUP_WAIT).
  - INIT: 0x38, 0x0C, 0x06, 0x01.
  - IDLE.
  - WRITE: 0x80 followed by 16 characters.
- LCD write cycle: set rs and lcd_db, raise e for E_PULSE cycles, drop e, then wait CMD_WAIT (CLEAR_WAIT for 0x01). rs and lcd_db stay stable while e is high.
- LCD message select, by priority:
  - etapa=11: "INGRESE CLAVE   "
  - etapa=10: "NUEVA CLAVE     "
  - any alarm: "ALARMA ACTIVA   "
  - etapa=01: "VIGILANDO       "
  - else: "DESARMADO       "
- Message changes: when the selected message changes, the FSM enters WRITE after the current write cycle completes. A change during WRITE restarts WRITE after the current string finishes.
- Simultaneous events: a sensor event and an enter press in the same cycle cannot conflict, because each is active only in its own stage. Reset mid-operation aborts any LCD transfer.

Test Plan:
- Hold rst2=0 then release, all inputs 0 -> alarms, buzzer_out and e are 0; disp=7'b1000000; after POWERUP_WAIT, bytes 0x38, 0x0C, 0x06, 0x01 are strobed with rs=0, then "DESARMADO" with rs=1.
- etapa=01, sensor=001, then sensor=101 -> alarm_out1=1; buzzer_out toggles every BUZZ_DIV cycles; disp shows "1" then "2"; LCD shows "ALARMA ACTIVA".
- Then sensor=000 with etapa=01 -> alarm_out1 stays 1; disp still shows "2".
- etapa=11; key fila=0001/Columna=001, release; key fila=0100/Columna=100, release; enter=1 -> disp shows "1" then "9"; after enter, alarm_out1=0, buzzer_out=0, zone latches 0.
- etapa=11, three wrong entries (e.g. "2","3", enter, each time) -> alarm_out2=1 after the 3rd enter; a subsequent correct "19"+enter clears it.
- etapa=10, keys "4","7", enter, no alarms -> new code 8'h47; in etapa=11, "19" is now rejected and "47" is accepted. Pressing two keys at once (fila=0011) -> no digit accepted.
